pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
- Control and hazard unit for the 5-stage RSA decryption ASIP datapath.
- Consumes the datapath's decoded fields: opcode, func, register indices, and the EX-stage zero flag.
- Drives the ID-stage control word, the forwarding selects, the branch code, and the stall/flush strobes.
- Internally shadows the EX, MEM and WB control bits, so hazard decisions never need extra datapath outputs.

Parameters:
- RW, 5, register index width.
- CW, 16, performance counter width (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  3  ID-stage opcode.
- func  in  2  ID-stage function field.
- ra_id, rb_id, rw_id  in  RW each  ID-stage source/destination indices.
- ra_ex, rb_ex, rw_ex, rw_mem, rw_wb  in  RW each  downstream indices.
- z  in  1  EX-stage ALU zero flag.
- forward_ra, forward_rb  out  2  00 regfile, 01 MEM ALU result, 10 WB data.
- branch  out  2  00 beq, 01 bne, 10 jmp, 11 none; applies to the instruction in EX.
- ext_selector  out  2  immediate extension mode.
- rb_selector, wr_en_id, opb_sel_id, alu_func_id, wd_sel_id, wm_en_id  out  1 each  ID control word.
- stall  out  1  hold PC and IF/ID; bubble ID/EX.
- flush_ifid, flush_idex  out  1 each  squash the named pipe register on the next edge.

Behaviour:
- Decode is combinational from opcode/func:
  - 000 R-type: wr_en=1, alu_func=func[0].
  - 001 I-type: wr_en=1, opb_sel=1, ext=00.
  - 010 load: wr_en=1, opb_sel=1, wd_sel=1.
  - 011 store: wm_en=1, opb_sel=1, rb_selector=1.
  - 100 branch: func 00/01/10 selects beq/bne/jmp, ext=01.
  - 101-111: nop (all enables 0).
- Writes with rw_id=0 force wr_en_id=0.
- Shadow registers wr_en_ex, load_ex, br_ex[1:0], wr_en_mem, wr_en_wb advance every edge from the gated ID control word.
- Forwarding selects:
  - 01 if wr_en_mem and rw_mem==src and src!=0.
  - Else 10 if wr_en_wb and rw_wb==src and src!=0.
  - Else 00.
  - MEM has priority over WB when both match.
- branch output = br_ex; it is 11 when EX holds no branch. taken = jmp | (beq & z) | (bne & ~z).
- FSM states RUN, STALL, FLUSH; reset state RUN.
  - RUN -> STALL when load_ex and (rw_ex==ra_id or (rb used and rw_ex==rb_id)) and rw_ex!=0.
  - RUN -> FLUSH when taken. Taken has priority over a simultaneous load-use stall.
  - STALL, 1 cycle: stall=1, ID control word gated to zero (bubble); then -> RUN.
  - FLUSH, 1 cycle: flush_ifid=1, flush_idex=1, ID control word gated to zero, shadow br_ex cleared; then -> RUN.
- Latency:
  - Load-use costs exactly 1 bubble.
  - Taken branch costs exactly 2 squashed instructions.
- Reset (asynchronous, mid-operation included):
  - All shadow registers, stall and flush outputs = 0.
  - branch=11, forward selects=00.
  - FSM returns to RUN immediately.
  - Decode outputs stay combinational.

Optional Feature:
- Macro PIPELINE_CONTROL_PERF_EN.
- When defined:
  - Adds outputs stall_count[CW-1:0] and flush_count[CW-1:0].
  - Each increments once on entry to STALL or FLUSH respectively.
  - Both saturate at all-ones and clear on reset.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package asip_ctrl_pkg holds:
  - opcode_t enum.
  - FWD_RF/FWD_MEM/FWD_WB constants.
  - BR_EQ/BR_NE/BR_JMP/BR_NONE constants.
  - ctrl_state_t {RUN, STALL, FLUSH}.
  - Packed ctrl_word_t struct.
- Sub-module forward_unit: purely combinational, instantiated once per operand (ra, rb).

Test Plan:
- R-type add r3 in MEM, next instruction reads r3 in EX (ra_ex=3, rw_mem=3, wr_en_mem=1) -> forward_ra=01.
- rw_mem=rw_wb=5 both writing, rb_ex=5 -> forward_rb=01 (MEM priority); writer to r0 -> forward stays 00.
- Load r4, then add using r4 -> stall=1 for exactly one cycle, wr_en_id=0 that cycle, then RUN with forward_ra=10 on the following cycle.
- beq in EX with z=1 -> branch=00, flush_ifid=flush_idex=1 for one cycle; same with z=0 -> no flush.
- Load-use and jmp taken in the same cycle -> FLUSH entered, stall=0; reset asserted during FLUSH -> flush outputs drop asynchronously, branch=11.
- With PIPELINE_CONTROL_PERF_EN and CW=4: 20 load-use stalls -> stall_count=15 (saturated).

Source files
------------

// File: rtl/asip_ctrl_pkg.sv
// asip_ctrl_pkg: shared types and constants for the ASIP pipeline control unit.
//   opcode_t     : ID-stage opcode encoding
//   FWD_*        : forwarding select codes
//   BR_*         : branch codes for the instruction in EX
//   ctrl_state_t : hazard FSM states
//   ctrl_word_t  : ID-stage control word, plus decode/uses_rb helpers
package asip_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_R  = 3'b000,
    OP_I  = 3'b001,
    OP_LD = 3'b010,
    OP_ST = 3'b011,
    OP_BR = 3'b100
  } opcode_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] BR_EQ   = 2'b00;
  localparam logic [1:0] BR_NE   = 2'b01;
  localparam logic [1:0] BR_JMP  = 2'b10;
  localparam logic [1:0] BR_NONE = 2'b11;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} ctrl_state_t;

  typedef struct packed {
    logic [1:0] ext;
    logic       rb_sel;
    logic       wr_en;
    logic       opb_sel;
    logic       alu_func;
    logic       wd_sel;
    logic       wm_en;
    logic [1:0] br;
  } ctrl_word_t;

  // Bubble word: no enables, and explicitly "no branch" (00 would mean beq).
  localparam ctrl_word_t CW_NOP = '{ext: 2'b00, rb_sel: 1'b0, wr_en: 1'b0,
                                    opb_sel: 1'b0, alu_func: 1'b0, wd_sel: 1'b0,
                                    wm_en: 1'b0, br: BR_NONE};

  function automatic ctrl_word_t decode(input logic [2:0] op, input logic [1:0] fn);
    ctrl_word_t w;
    w = CW_NOP;
    case (op)
      OP_R:  begin w.wr_en = 1'b1; w.alu_func = fn[0]; end
      OP_I:  begin w.wr_en = 1'b1; w.opb_sel = 1'b1; w.ext = 2'b00; end
      OP_LD: begin w.wr_en = 1'b1; w.opb_sel = 1'b1; w.wd_sel = 1'b1; end
      OP_ST: begin w.wm_en = 1'b1; w.opb_sel = 1'b1; w.rb_sel = 1'b1; end
      OP_BR: begin w.ext = 2'b01; w.br = (fn == 2'b11) ? BR_NONE : fn; end
      default: w = CW_NOP;
    endcase
    return w;
  endfunction

  // Instructions that read the rb operand (R-type, store data, branch compare).
  function automatic logic uses_rb(input logic [2:0] op);
    return (op == OP_R) || (op == OP_ST) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational forwarding select for one EX source operand.
//   i_src               : EX-stage source register index
//   i_wr_en_mem/i_rw_mem: MEM-stage writer
//   i_wr_en_wb/i_rw_wb  : WB-stage writer
//   o_sel               : FWD_RF / FWD_MEM / FWD_WB (MEM wins over WB)
module forward_unit
  import asip_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] i_src,
  input  logic          i_wr_en_mem,
  input  logic [RW-1:0] i_rw_mem,
  input  logic          i_wr_en_wb,
  input  logic [RW-1:0] i_rw_wb,
  output logic [1:0]    o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_src != '0) begin
      if (i_wr_en_mem && (i_rw_mem == i_src))     o_sel = FWD_MEM;
      else if (i_wr_en_wb && (i_rw_wb == i_src))  o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: control/hazard unit for the 5-stage RSA decryption ASIP.
//   Inputs : clock, reset (async active-low), opcode/func, ID and downstream
//            register indices, EX zero flag z.
//   Outputs: ID control word, forward_ra/rb, branch (EX), stall, flush_ifid,
//            flush_idex.
//   Optional macro PIPELINE_CONTROL_PERF_EN adds saturating stall_count and
//   flush_count outputs (CW bits wide).
module pipeline_control
  import asip_ctrl_pkg::*;
#(
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    opcode,
  input  logic [1:0]    func,
  input  logic [RW-1:0] ra_id,
  input  logic [RW-1:0] rb_id,
  input  logic [RW-1:0] rw_id,
  input  logic [RW-1:0] ra_ex,
  input  logic [RW-1:0] rb_ex,
  input  logic [RW-1:0] rw_ex,
  input  logic [RW-1:0] rw_mem,
  input  logic [RW-1:0] rw_wb,
  input  logic          z,
  output logic [1:0]    forward_ra,
  output logic [1:0]    forward_rb,
  output logic [1:0]    branch,
  output logic [1:0]    ext_selector,
  output logic          rb_selector,
  output logic          wr_en_id,
  output logic          opb_sel_id,
  output logic          alu_func_id,
  output logic          wd_sel_id,
  output logic          wm_en_id,
  output logic          stall,
  output logic          flush_ifid,
  output logic          flush_idex
`ifdef PIPELINE_CONTROL_PERF_EN
  ,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
`endif
);

  ctrl_state_t r_state, w_state_nxt;
  ctrl_word_t  w_dec, w_word;
  logic        r_wr_en_ex, r_load_ex, r_wr_en_mem, r_wr_en_wb;
  logic [1:0]  r_br_ex;
  logic        w_taken, w_load_use;

  // Decode; a write to r0 is never a real write.
  always_comb begin
    w_dec = decode(opcode, func);
    if (rw_id == '0) w_dec.wr_en = 1'b0;
  end

  // Bubble the ID word whenever the FSM is stalling or flushing.
  assign w_word = (r_state == RUN) ? w_dec : CW_NOP;

  assign ext_selector = w_word.ext;
  assign rb_selector  = w_word.rb_sel;
  assign wr_en_id     = w_word.wr_en;
  assign opb_sel_id   = w_word.opb_sel;
  assign alu_func_id  = w_word.alu_func;
  assign wd_sel_id    = w_word.wd_sel;
  assign wm_en_id     = w_word.wm_en;
  assign branch       = r_br_ex;

  assign w_taken    = (r_br_ex == BR_JMP) || ((r_br_ex == BR_EQ) && z) ||
                      ((r_br_ex == BR_NE) && !z);
  assign w_load_use = r_load_ex && (rw_ex != '0) &&
                      ((rw_ex == ra_id) || (uses_rb(opcode) && (rw_ex == rb_id)));

  // Taken branch outranks load-use: the dependent instruction gets squashed anyway.
  always_comb begin
    w_state_nxt = RUN;
    stall       = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_taken)         w_state_nxt = FLUSH;
        else if (w_load_use) w_state_nxt = STALL;
      end
      STALL: stall = 1'b1;
      FLUSH: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Shadow of downstream control bits; br_ex idles at BR_NONE, not 00 (beq).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_en_ex  <= 1'b0;
      r_load_ex   <= 1'b0;
      r_br_ex     <= BR_NONE;
      r_wr_en_mem <= 1'b0;
      r_wr_en_wb  <= 1'b0;
    end else begin
      r_wr_en_ex  <= w_word.wr_en;
      r_load_ex   <= w_word.wd_sel;
      r_br_ex     <= (r_state == FLUSH) ? BR_NONE : w_word.br;
      r_wr_en_mem <= r_wr_en_ex;
      r_wr_en_wb  <= r_wr_en_mem;
    end
  end

  forward_unit #(.RW(RW)) u_fwd_ra (
    .i_src(ra_ex), .i_wr_en_mem(r_wr_en_mem), .i_rw_mem(rw_mem),
    .i_wr_en_wb(r_wr_en_wb), .i_rw_wb(rw_wb), .o_sel(forward_ra)
  );

  forward_unit #(.RW(RW)) u_fwd_rb (
    .i_src(rb_ex), .i_wr_en_mem(r_wr_en_mem), .i_rw_mem(rw_mem),
    .i_wr_en_wb(r_wr_en_wb), .i_rw_wb(rw_wb), .o_sel(forward_rb)
  );

`ifdef PIPELINE_CONTROL_PERF_EN
  logic [CW-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state == RUN) begin
      if (w_state_nxt == STALL && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_state_nxt == FLUSH && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: randomized scoreboard bench for pipeline_control.
// Stimulus computes expected outputs from a stage-list model and queues them;
// a monitor on the falling edge pops and compares.
module tb_pipeline_control;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    opcode;
  logic [1:0]    func;
  logic [RW-1:0] ra_id, rb_id, rw_id, ra_ex, rb_ex, rw_ex, rw_mem, rw_wb;
  logic          z;
  logic [1:0]    forward_ra, forward_rb, branch, ext_selector;
  logic          rb_selector, wr_en_id, opb_sel_id, alu_func_id, wd_sel_id, wm_en_id;
  logic          stall, flush_ifid, flush_idex;
`ifdef PIPELINE_CONTROL_PERF_EN
  logic [CW-1:0] stall_count, flush_count;
`endif

  pipeline_control #(.RW(RW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .func(func),
    .ra_id(ra_id), .rb_id(rb_id), .rw_id(rw_id),
    .ra_ex(ra_ex), .rb_ex(rb_ex), .rw_ex(rw_ex), .rw_mem(rw_mem), .rw_wb(rw_wb),
    .z(z), .forward_ra(forward_ra), .forward_rb(forward_rb), .branch(branch),
    .ext_selector(ext_selector), .rb_selector(rb_selector), .wr_en_id(wr_en_id),
    .opb_sel_id(opb_sel_id), .alu_func_id(alu_func_id), .wd_sel_id(wd_sel_id),
    .wm_en_id(wm_en_id), .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex)
`ifdef PIPELINE_CONTROL_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  // {fwd_ra, fwd_rb, branch, ext, rb_sel, wr, opb, alu, wd, wm, stall, flush_ifid, flush_idex}
  typedef logic [16:0] obs_t;
  obs_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: what sits in EX/MEM/WB, plus the penalty owed this cycle
  // (0 none, 1 bubble, 2 squash).
  int         pend;
  logic       ex_wr, ex_ld, mem_wr, wb_wr;
  logic [1:0] ex_br;
  int         n_stall, n_flush;

  // {ext, rb_sel, wr, opb, alu, wd, wm, br}
  function automatic logic [9:0] ref_dec(input logic [2:0] op, input logic [1:0] fn);
    case (op)
      3'd0: return {2'b00, 1'b0, 1'b1, 1'b0, fn[0], 1'b0, 1'b0, 2'b11};
      3'd1: return {2'b00, 1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 2'b11};
      3'd2: return {2'b00, 1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 2'b11};
      3'd3: return {2'b00, 1'b1, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 2'b11};
      3'd4: return {2'b01, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, fn};
      default: return {8'b0, 2'b11};
    endcase
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] src);
    if (src == 0) return 2'd0;
    if (mem_wr && rw_mem == src) return 2'd1;
    if (wb_wr && rw_wb == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    pend = 0; ex_wr = 0; ex_ld = 0; ex_br = 2'b11; mem_wr = 0; wb_wr = 0;
    n_stall = 0; n_flush = 0;
  endtask

  task automatic cycle(input bit do_rst);
    logic [9:0] d;
    logic       taken, lu, rb_used;
    @(posedge clock); #2;
    opcode = 3'($urandom_range(0, 7));
    func   = 2'($urandom_range(0, 3));
    ra_id  = RW'($urandom_range(0, 3)); rb_id = RW'($urandom_range(0, 3));
    rw_id  = RW'($urandom_range(0, 3)); ra_ex = RW'($urandom_range(0, 3));
    rb_ex  = RW'($urandom_range(0, 3)); rw_ex = RW'($urandom_range(0, 3));
    rw_mem = RW'($urandom_range(0, 3)); rw_wb = RW'($urandom_range(0, 3));
    z      = 1'($urandom_range(0, 1));
    reset  = !do_rst;
    if (do_rst) model_reset();
    d = ref_dec(opcode, func);
    if (rw_id == 0) d[6] = 1'b0;
    if (pend != 0) d = {8'b0, 2'b11};
    exp_q.push_back({ref_fwd(ra_ex), ref_fwd(rb_ex), ex_br, d[9:2],
                     pend == 1, pend == 2, pend == 2});
    if (!do_rst) begin
      taken   = (ex_br == 2'd2) || (ex_br == 2'd0 && z) || (ex_br == 2'd1 && !z);
      rb_used = (opcode == 3'd0) || (opcode == 3'd3) || (opcode == 3'd4);
      lu      = ex_ld && rw_ex != 0 && (rw_ex == ra_id || (rb_used && rw_ex == rb_id));
      wb_wr  = mem_wr;
      mem_wr = ex_wr;
      ex_wr  = d[6];
      ex_ld  = d[3];
      ex_br  = d[1:0];
      if (pend != 0)  pend = 0;
      else if (taken) begin pend = 2; n_flush++; end
      else if (lu)    begin pend = 1; n_stall++; end
    end
  endtask

  initial begin : monitor
    obs_t a, e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {forward_ra, forward_rb, branch, ext_selector, rb_selector, wr_en_id,
             opb_sel_id, alu_func_id, wd_sel_id, wm_en_id, stall, flush_ifid, flush_idex};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL outputs t=%0t got %h expected %h", $time, a, e);
      end
    end
  end

  initial begin : stim
    bit hit;
    reset = 1'b0; opcode = '0; func = '0; z = 1'b0;
    ra_id = '0; rb_id = '0; rw_id = '0; ra_ex = '0; rb_ex = '0; rw_ex = '0;
    rw_mem = '0; rw_wb = '0;
    model_reset();
    cycle(1); cycle(1);
    for (int i = 0; i < 600; i++) cycle(0);
    // Assert reset in the middle of a flush cycle.
    hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      if (pend == 2) begin cycle(1); hit = 1; end
      else cycle(0);
    end
    if (!hit) begin
      n_total++;
      $display("FAIL flush_reach got no flush expected one within 300 cycles");
    end
    for (int i = 0; i < 200; i++) cycle(0);
    @(negedge clock); @(negedge clock);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending expected 0", exp_q.size());
`ifdef PIPELINE_CONTROL_PERF_EN
    n_total++;
    if (int'(stall_count) == ((n_stall > 15) ? 15 : n_stall)) n_pass++;
    else $display("FAIL stall_count got %0d expected %0d", stall_count, (n_stall > 15) ? 15 : n_stall);
    n_total++;
    if (int'(flush_count) == ((n_flush > 15) ? 15 : n_flush)) n_pass++;
    else $display("FAIL flush_count got %0d expected %0d", flush_count, (n_flush > 15) ? 15 : n_flush);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
